// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 size codes,
// FSM state type and the access-error helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Combines misalignment, range and funct3 legality into one error flag.
  // Stores only support the signed size codes; loads also accept BU/HU.
  function automatic logic addr_error(input logic       write,
                                      input logic [2:0] funct3,
                                      input logic       misalign,
                                      input logic       out_of_range);
    logic bad_f3;
    if (write) begin
      bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W});
    end else begin
      bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
    return bad_f3 || misalign || out_of_range;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads and stores: extracts and extends load
// data, merges store data into the stored word, and flags misalignment.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store,
  output logic        o_misalign
);

  logic [31:0] w_shifted;
  logic [31:0] w_mask;
  logic [31:0] w_wrep;
  logic        w_signed;

  // Select lanes by address, extend loads, build store merge mask.
  always_comb begin
    w_shifted  = i_rword >> {i_addr_lo, 3'b000};
    w_signed   = !i_funct3[2];
    o_load     = '0;
    w_mask     = '0;
    w_wrep     = '0;
    o_misalign = 1'b0;
    case (i_funct3[1:0])
      2'b00: begin
        o_load = w_signed ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                          : {24'd0, w_shifted[7:0]};
        w_mask = 32'h0000_00FF << {i_addr_lo, 3'b000};
        w_wrep = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_load     = w_signed ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                              : {16'd0, w_shifted[15:0]};
        w_mask     = 32'h0000_FFFF << {i_addr_lo[1], 4'b0000};
        w_wrep     = {2{i_wdata[15:0]}};
        o_misalign = i_addr_lo[0];
      end
      2'b10: begin
        o_load     = i_rword;
        w_mask     = '1;
        w_wrep     = i_wdata;
        o_misalign = (i_addr_lo != 2'b00);
      end
      default: begin
        o_load = '0;
      end
    endcase
    o_store = (i_rword & ~w_mask) | (w_wrep & w_mask);
  end

endmodule

// File: rtl/data_mem_responder.sv
// Latency-programmable memory responder for the core's load/store port:
// one outstanding request, valid/ready request and response channels.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned IDXW = $clog2(DEPTH_WORDS);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic                  r_write;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_mem [DEPTH_WORDS];

  logic [IDXW-1:0]       w_idx;
  logic                  w_oor;
  logic [31:0]           w_rword;
  logic [31:0]           w_load;
  logic [31:0]           w_store;
  logic                  w_misalign;
  logic                  w_err;
  logic                  w_exec;
  logic                  w_we;

  assign w_idx   = r_addr[IDXW+1:2];
  assign w_oor   = (r_addr >> (IDXW + 2)) != '0;
  assign w_rword = r_mem[w_idx];
  assign w_err   = addr_error(r_write, r_funct3, w_misalign, w_oor);
  assign w_exec  = (r_state == BUSY) && (r_cnt == '0);
  assign w_we    = w_exec && r_write && !w_err;

  mem_lane_align u_align (
    .i_funct3   (r_funct3),
    .i_addr_lo  (r_addr[1:0]),
    .i_rword    (w_rword),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_store    (w_store),
    .o_misalign (w_misalign)
  );

  // Storage commit: only on the BUSY->RESP edge of an error-free store.
  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem[w_idx] <= w_store;
    end
  end

  // Request/response FSM with latency counter and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_write      <= 1'b0;
      r_funct3     <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_funct3    <= req_funct3;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_cnt       <= 4'(LATENCY - 1);
            r_req_ready <= 1'b0;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_resp_valid <= 1'b1;
            r_err        <= w_err;
            r_rdata      <= (w_err || r_write) ? '0 : w_load;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
